// File: rtl/inst_cache_dm.sv
// Direct-mapped, read-only instruction cache: zero-latency hits, single-line
// refill from backing memory one word per accepted beat on a miss.
module inst_cache_dm #(
    parameter int BUS_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_n,
    input  logic                  i_FetchValid,
    input  logic [ADDR_WIDTH-1:0] i_FetchAddr,
    input  logic                  i_Flush,
    output logic [BUS_WIDTH-1:0]  o_Instruction,
    output logic                  o_InstValid,
    output logic                  o_Stall,
    output logic                  o_MemReq,
    output logic [ADDR_WIDTH-1:0] o_MemAddr,
    input  logic                  i_MemValid,
    input  logic [BUS_WIDTH-1:0]  i_MemData,
    output logic [CNT_WIDTH-1:0]  o_MissCount
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_LSB = OFF_W + IDX_W + 2;
    localparam int TAG_W = ADDR_WIDTH - TAG_LSB;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_WORDS * 4 - 1);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t                 state_q, state_d;
    logic [OFF_W-1:0]       beat_q, beat_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [CNT_WIDTH-1:0]   miss_cnt_q, miss_cnt_d;
    logic [TAG_W-1:0]       tag_q [NUM_LINES];
    logic [TAG_W-1:0]       tag_d [NUM_LINES];
    logic [BUS_WIDTH-1:0]   data_q [NUM_LINES][LINE_WORDS];
    logic [BUS_WIDTH-1:0]   data_d [NUM_LINES][LINE_WORDS];

    logic [OFF_W-1:0] fetch_off;
    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             hit;

    assign fetch_off = i_FetchAddr[OFF_W+1:2];
    assign fetch_idx = i_FetchAddr[TAG_LSB-1:OFF_W+2];
    assign fetch_tag = i_FetchAddr[ADDR_WIDTH-1:TAG_LSB];
    assign fill_idx  = base_q[TAG_LSB-1:OFF_W+2];
    assign fill_tag  = base_q[ADDR_WIDTH-1:TAG_LSB];

    // A flush in the same cycle as a fetch forces a miss even if the line is present.
    assign hit = i_FetchValid & valid_q[fetch_idx] & (tag_q[fetch_idx] == fetch_tag) & ~i_Flush;

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        base_d        = base_q;
        flush_pend_d  = flush_pend_q;
        valid_d       = valid_q;
        miss_cnt_d    = miss_cnt_q;
        tag_d         = tag_q;
        data_d        = data_q;
        o_Instruction = '0;
        o_InstValid   = 1'b0;
        o_Stall       = 1'b0;
        o_MemReq      = 1'b0;
        o_MemAddr     = '0;

        case (state_q)
            S_IDLE: begin
                if (i_FetchValid) begin
                    if (hit) begin
                        o_Instruction = data_q[fetch_idx][fetch_off];
                        o_InstValid   = 1'b1;
                    end else begin
                        o_Stall            = 1'b1;
                        base_d             = i_FetchAddr & ~LINE_MASK;
                        beat_d             = '0;
                        valid_d[fetch_idx] = 1'b0;
                        if (miss_cnt_q != {CNT_WIDTH{1'b1}}) begin
                            miss_cnt_d = miss_cnt_q + 1'b1;
                        end
                        state_d = S_FILL;
                    end
                end
                if (i_Flush) begin
                    valid_d = '0;
                end
            end
            S_FILL: begin
                o_Stall   = 1'b1;
                o_MemReq  = 1'b1;
                o_MemAddr = base_q + ADDR_WIDTH'({beat_q, 2'b00});
                if (i_Flush) begin
                    flush_pend_d = 1'b1;
                end
                if (i_MemValid) begin
                    data_d[fill_idx][beat_q] = i_MemData;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) begin
                        tag_d[fill_idx]   = fill_tag;
                        valid_d[fill_idx] = 1'b1;
                        // A flush seen anytime during the fill drops the new line too.
                        if (flush_pend_q | i_Flush) begin
                            valid_d = '0;
                        end
                        flush_pend_d = 1'b0;
                        beat_d       = '0;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            base_q       <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            base_q       <= base_d;
            flush_pend_q <= flush_pend_d;
            valid_q      <= valid_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    // Tag and data contents are qualified by valid bits, so they need no reset.
    always_ff @(posedge i_Clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign o_MissCount = miss_cnt_q;

endmodule

// File: tb/tb_inst_cache_dm.sv
// Randomised bench for inst_cache_dm against a line-level cache model; a second
// instance with a 2-bit miss counter shares the stimulus to exercise saturation.
module tb_inst_cache_dm;

    localparam int NL = 8;
    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic        flush;
    logic        mem_valid;
    logic [31:0] mem_data;

    logic [31:0] instr, instr_s;
    logic        inst_valid, inst_valid_s;
    logic        stall, stall_s;
    logic        mem_req, mem_req_s;
    logic [31:0] mem_addr, mem_addr_s;
    logic [15:0] miss_count;
    logic [1:0]  miss_count_s;

    always #5 clk = ~clk;

    inst_cache_dm dut (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_FetchValid(fetch_valid), .i_FetchAddr(fetch_addr),
        .i_Flush(flush), .o_Instruction(instr), .o_InstValid(inst_valid), .o_Stall(stall),
        .o_MemReq(mem_req), .o_MemAddr(mem_addr), .i_MemValid(mem_valid), .i_MemData(mem_data),
        .o_MissCount(miss_count)
    );

    inst_cache_dm #(.CNT_WIDTH(2)) dut_sat (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_FetchValid(fetch_valid), .i_FetchAddr(fetch_addr),
        .i_Flush(flush), .o_Instruction(instr_s), .o_InstValid(inst_valid_s), .o_Stall(stall_s),
        .o_MemReq(mem_req_s), .o_MemAddr(mem_addr_s), .i_MemValid(mem_valid), .i_MemData(mem_data),
        .o_MissCount(miss_count_s)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: which line holds which tag, and how many misses have occurred.
    bit          m_valid [NL];
    int unsigned m_tag   [NL];
    int          m_misses;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'hFFFF_FFFC;
        case (w)
            32'h0000_0000: return 32'h0020_01B3;
            32'h0000_0004: return 32'h4021_80B3;
            32'h0000_0008: return 32'h001F_0FB3;
            32'h0000_000C: return 32'h0080_2F03;
            default:       return (w * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    task automatic check_counts;
        check("miss_count", {16'd0, miss_count}, 32'(m_misses));
        check("miss_count_sat", {30'd0, miss_count_s}, (m_misses > 3) ? 32'd3 : 32'(m_misses));
    endtask

    task automatic do_flush_idle;
        fetch_valid = 1'b0;
        mem_valid   = 1'b0;
        flush       = 1'b1;
        tick();
        flush = 1'b0;
        model_clear();
        $display("flush idle");
    endtask

    // One fetch transaction; on a miss serves the refill with idle gaps of
    // idle_min..idle_max cycles, optionally flushing or resetting at a beat.
    task automatic fetch(input logic [31:0] addr, input int idle_min, input int idle_max,
                         input int flush_beat, input int rst_beat, input bit flush_now);
        logic [31:0] base;
        int          idx;
        int unsigned tg;
        bit          exp_hit;
        bit          fl;
        idx  = int'((addr >> 4) & 32'h7);
        tg   = addr >> 7;
        base = addr & 32'hFFFF_FFF0;
        exp_hit = !flush_now && m_valid[idx] && (m_tag[idx] == tg);

        fetch_valid = 1'b1;
        fetch_addr  = addr;
        flush       = flush_now;
        mem_valid   = 1'($urandom_range(0, 1));
        mem_data    = $urandom;
        @(negedge clk);
        if (exp_hit) begin
            check("hit_valid", {31'd0, inst_valid}, 32'd1);
            check("hit_instr", instr, mem_word(addr));
            check("hit_stall", {31'd0, stall}, 32'd0);
            check("hit_memreq", {31'd0, mem_req}, 32'd0);
            check_counts();
            tick();
            $display("fetch %h hit instr=%h", addr, instr);
            return;
        end
        check("miss_valid", {31'd0, inst_valid}, 32'd0);
        check("miss_instr", instr, 32'd0);
        check("miss_stall", {31'd0, stall}, 32'd1);
        check("miss_memreq", {31'd0, mem_req}, 32'd0);
        tick();
        flush = 1'b0;
        if (flush_now) model_clear();
        m_valid[idx] = 1'b0;
        m_misses++;
        fl = 1'b0;

        for (int k = 0; k < LW; k++) begin
            repeat ($urandom_range(idle_min, idle_max)) begin
                mem_valid  = 1'b0;
                fetch_addr = $urandom;
                @(negedge clk);
                check("wait_addr", mem_addr, base + 32'(4 * k));
                check("wait_req", {31'd0, mem_req}, 32'd1);
                check("wait_stall", {31'd0, stall}, 32'd1);
                check("wait_valid", {31'd0, inst_valid}, 32'd0);
                tick();
            end
            if (k == rst_beat) begin
                rst_n       = 1'b0;
                fetch_valid = 1'b0;
                mem_valid   = 1'b0;
                tick();
                rst_n = 1'b1;
                model_clear();
                m_misses = 0;
                @(negedge clk);
                check("rst_req", {31'd0, mem_req}, 32'd0);
                check("rst_stall", {31'd0, stall}, 32'd0);
                check("rst_valid", {31'd0, inst_valid}, 32'd0);
                check("rst_addr", mem_addr, 32'd0);
                check_counts();
                tick();
                $display("fetch %h miss, reset at beat %0d", addr, k);
                return;
            end
            mem_valid  = 1'b1;
            mem_data   = mem_word(base + 32'(4 * k));
            flush      = (k == flush_beat);
            fl         = fl | flush;
            fetch_addr = $urandom;
            @(negedge clk);
            check("beat_addr", mem_addr, base + 32'(4 * k));
            check("beat_req", {31'd0, mem_req}, 32'd1);
            check("beat_stall", {31'd0, stall}, 32'd1);
            check("beat_instr", instr, 32'd0);
            tick();
            flush = 1'b0;
        end
        mem_valid   = 1'b0;
        fetch_valid = 1'b0;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tg;
        if (fl) model_clear();
        @(negedge clk);
        check("done_req", {31'd0, mem_req}, 32'd0);
        check("done_stall", {31'd0, stall}, 32'd0);
        check_counts();
        tick();
        $display("fetch %h miss, refilled line %h%s", addr, base, fl ? " (flushed)" : "");
    endtask

    initial begin
        logic [31:0] a;
        rst_n       = 1'b0;
        fetch_valid = 1'b0;
        fetch_addr  = '0;
        flush       = 1'b0;
        mem_valid   = 1'b0;
        mem_data    = '0;
        model_clear();
        for (int i = 0; i < NL; i++) m_tag[i] = 0;
        m_misses = 0;
        tick();
        tick();
        @(negedge clk);
        check("reset_instr", instr, 32'd0);
        check("reset_valid", {31'd0, inst_valid}, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_req", {31'd0, mem_req}, 32'd0);
        check("reset_addr", mem_addr, 32'd0);
        check_counts();
        rst_n = 1'b1;
        tick();

        // Cold miss and same-line hits
        fetch(32'h00, 0, 0, -1, -1, 1'b0);
        fetch(32'h00, 0, 0, -1, -1, 1'b0);
        fetch(32'h0C, 0, 0, -1, -1, 1'b0);
        // Backpressure: three idle cycles before every beat
        fetch(32'h14, 3, 3, -1, -1, 1'b0);
        fetch(32'h18, 0, 0, -1, -1, 1'b0);
        // Conflict eviction on index 0
        fetch(32'h80, 0, 1, -1, -1, 1'b0);
        fetch(32'h84, 0, 0, -1, -1, 1'b0);
        fetch(32'h00, 0, 1, -1, -1, 1'b0);
        fetch(32'h08, 0, 0, -1, -1, 1'b0);
        // Flush while idle, flush with simultaneous fetch, flush mid-fill
        do_flush_idle();
        fetch(32'h00, 0, 0, -1, -1, 1'b0);
        fetch(32'h04, 0, 0, -1, -1, 1'b1);
        fetch(32'h20, 0, 2, 1, -1, 1'b0);
        fetch(32'h20, 0, 0, -1, -1, 1'b0);
        fetch(32'h24, 0, 0, -1, -1, 1'b0);
        // Reset in the middle of a fill
        fetch(32'h40, 0, 1, -1, 2, 1'b0);
        fetch(32'h00, 0, 0, -1, -1, 1'b0);
        fetch(32'h00, 0, 0, -1, -1, 1'b0);
        // Five forced misses to saturate the narrow counter
        for (int i = 0; i < 5; i++) fetch(32'h100 + 32'(i * 16) + 32'h1000, 0, 0, -1, -1, 1'b0);

        for (int n = 0; n < 80; n++) begin
            a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2);
            if ($urandom_range(0, 19) == 0) do_flush_idle();
            fetch(a, 0, $urandom_range(0, 2),
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1,
                  ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 3)) : -1,
                  1'($urandom_range(0, 9) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
